alu_issue_ctrl: RTL

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// Issues one ALU operation at a time and waits a per-class fixed latency before capturing the result.
// Latency: accept-to-result LAT_SIMPLE/LAT_MUL/LAT_DIV edges; results hold under res_ready=0; flush aborts.
module alu_issue_ctrl #(
    parameter int LAT_SIMPLE = 2,   // legal range 1..63
    parameter int LAT_MUL    = 4,   // legal range 1..63
    parameter int LAT_DIV    = 34   // legal range 1..63
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_opcode,
    input  logic [31:0] req_op1,
    input  logic [31:0] req_op2,
    output logic [31:0] alu_operator_1,
    output logic [31:0] alu_operator_2,
    output logic [4:0]  alu_opcode,
    input  logic [31:0] alu_answer,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    input  logic        flush,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam logic [5:0] CNT_SIMPLE = 6'(LAT_SIMPLE - 1);
    localparam logic [5:0] CNT_MUL    = 6'(LAT_MUL - 1);
    localparam logic [5:0] CNT_DIV    = 6'(LAT_DIV - 1);

    state_t     state;
    state_t     state_nxt;
    logic [5:0] cnt;
    logic [5:0] cnt_nxt;
    logic       armed;
    logic       accept;
    logic       capture;

    // 5'h08..5'h0B multiply, 5'h0C..5'h0F divide, everything else simple
    function automatic logic [5:0] lat_load(input logic [4:0] opc);
        if (opc[4:2] == 3'b010) begin
            return CNT_MUL;
        end else if (opc[4:2] == 3'b011) begin
            return CNT_DIV;
        end else begin
            return CNT_SIMPLE;
        end
    endfunction

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        capture   = 1'b0;
        req_ready = armed && (state == ST_IDLE) && !flush;
        res_valid = (state == ST_DONE);
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    accept    = 1'b1;
                    cnt_nxt   = lat_load(req_opcode);
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    cnt_nxt   = 6'd0;
                    state_nxt = ST_IDLE;
                end else if (cnt == 6'd0) begin
                    capture   = 1'b1;
                    state_nxt = ST_DONE;
                end else begin
                    cnt_nxt = cnt - 6'd1;
                end
            end
            ST_DONE: begin
                // flush takes priority over the handshake; either way the slot frees up
                if (flush || res_ready) begin
                    cnt_nxt   = 6'd0;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                cnt_nxt   = 6'd0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= 6'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // armed keeps req_ready low until the first clock edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed          <= 1'b0;
            alu_operator_1 <= 32'd0;
            alu_operator_2 <= 32'd0;
            alu_opcode     <= 5'd0;
            res_data       <= 32'd0;
        end else begin
            armed <= 1'b1;
            if (accept) begin
                alu_operator_1 <= req_op1;
                alu_operator_2 <= req_op2;
                alu_opcode     <= req_opcode;
            end
            if (capture) begin
                res_data <= alu_answer;
            end
        end
    end

endmodule
